// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM compare unit.
package pwm_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;
    localparam int unsigned RESET_DUTY_DEFAULT = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PENDING = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_duty_shadow_reg.sv
// Duty write handshake, shadow register and period-boundary transfer into the active duty.
module pwm_duty_shadow_reg
    import pwm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned RESET_DUTY = RESET_DUTY_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] duty_value_i,
    input  logic                  duty_valid_i,
    input  logic                  direct_load_i,
    input  logic                  transfer_i,
    output logic                  duty_ready_o,
    output logic                  accept_c_o,
    output logic [DATA_WIDTH-1:0] eff_duty_c_o
);

    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  accept_c;

    assign accept_c     = duty_valid_i && !pending_q;
    assign accept_c_o   = accept_c;
    assign duty_ready_o = !pending_q;
    // A transferring cycle already compares against the incoming value, so count 0 of the new period is clean.
    assign eff_duty_c_o = transfer_i ? shadow_q : active_q;

    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        if (accept_c) begin
            shadow_d = duty_value_i;
            if (direct_load_i) begin
                active_d = duty_value_i;
            end else begin
                pending_d = 1'b1;
            end
        end
        if (transfer_i) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            shadow_q  <= DATA_WIDTH'(RESET_DUTY);
            active_q  <= DATA_WIDTH'(RESET_DUTY);
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/pwm_compare_unit_16_bit.sv
// PWM generator driven by an external MOD counter: duty FSM, registered compare outputs and sticky period IRQ.
module pwm_compare_unit_16_bit
    import pwm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned RESET_DUTY = RESET_DUTY_DEFAULT
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic [DATA_WIDTH-1:0] Counter_Count_In,
    input  logic                  Counter_Rollover_Flag_In,
    input  logic                  Counter_Running_Flag_In,
    input  logic                  Polarity_In,
    input  logic [DATA_WIDTH-1:0] Duty_Value_In,
    input  logic                  Duty_Write_Valid_In,
    output logic                  Duty_Write_Ready_Out,
    input  logic                  IRQ_Clear_In,
    output logic                  PWM_Out,
    output logic                  Compare_Match_Pulse_Out,
    output logic                  Period_Done_IRQ_Out
);

    pwm_state_t            state_q, state_d;
    logic                  transfer_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] eff_duty_c;
    logic                  match_c;
    logic                  pwm_q, pwm_d;
    logic                  pulse_q, pulse_d;
    logic                  irq_q, irq_d;

    pwm_duty_shadow_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_DUTY (RESET_DUTY)
    ) u_shadow (
        .clk_i         (Clk_In),
        .rst_i         (Reset_In),
        .duty_value_i  (Duty_Value_In),
        .duty_valid_i  (Duty_Write_Valid_In),
        .direct_load_i (state_q == S_IDLE),
        .transfer_i    (transfer_c),
        .duty_ready_o  (Duty_Write_Ready_Out),
        .accept_c_o    (accept_c),
        .eff_duty_c_o  (eff_duty_c)
    );

    // Duty-update FSM; a write during S_RUN waits in S_PENDING for the next period boundary.
    always_comb begin
        state_d    = state_q;
        transfer_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Counter_Running_Flag_In) state_d = S_RUN;
            end
            S_RUN: begin
                if (accept_c) begin
                    state_d = S_PENDING;
                end else if (!Counter_Running_Flag_In) begin
                    state_d = S_IDLE;
                end
            end
            S_PENDING: begin
                if (!Counter_Running_Flag_In) begin
                    transfer_c = 1'b1;
                    state_d    = S_IDLE;
                end else if (Counter_Rollover_Flag_In) begin
                    transfer_c = 1'b1;
                    state_d    = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign match_c = Counter_Running_Flag_In && (Counter_Count_In < eff_duty_c);

    always_comb begin
        pwm_d   = Polarity_In;
        pulse_d = 1'b0;
        irq_d   = irq_q;
        if (Enable_In && Counter_Running_Flag_In) begin
            pwm_d   = match_c ^ Polarity_In;
            pulse_d = (Counter_Count_In == eff_duty_c) && (eff_duty_c != '0);
        end
        // Set takes priority over a simultaneous clear.
        if (Enable_In && Counter_Rollover_Flag_In) begin
            irq_d = 1'b1;
        end else if (IRQ_Clear_In) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= S_IDLE;
            pwm_q   <= 1'b0;
            pulse_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            pulse_q <= pulse_d;
            irq_q   <= irq_d;
        end
    end

    assign PWM_Out                 = pwm_q;
    assign Compare_Match_Pulse_Out = pulse_q;
    assign Period_Done_IRQ_Out     = irq_q;

endmodule

// File: tb/tb_pwm_compare_unit_16_bit.sv
// Bench for pwm_compare_unit_16_bit with an inline MOD=10 counter and a queued expected-response checker.
module tb_pwm_compare_unit_16_bit;

    typedef struct packed {
        logic        pwm;
        logic        pulse;
        logic        irq;
        logic        rdy;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] cnt;
    logic        roll;
    logic        run;
    logic        pol;
    logic [15:0] dval;
    logic        dvalid;
    logic        dready;
    logic        clr;
    logic        pwm;
    logic        pulse;
    logic        irq;

    logic [15:0] act;
    logic        exp_irq;
    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_compare_unit_16_bit dut (
        .Clk_In                   (clk),
        .Reset_In                 (rst),
        .Enable_In                (en),
        .Counter_Count_In         (cnt),
        .Counter_Rollover_Flag_In (roll),
        .Counter_Running_Flag_In  (run),
        .Polarity_In              (pol),
        .Duty_Value_In            (dval),
        .Duty_Write_Valid_In      (dvalid),
        .Duty_Write_Ready_Out     (dready),
        .IRQ_Clear_In             (clr),
        .PWM_Out                  (pwm),
        .Compare_Match_Pulse_Out  (pulse),
        .Period_Done_IRQ_Out      (irq)
    );

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b (cnt=%0d duty=%0d)", name, cyc, got, want, cnt, act);
        end
    endtask

    // Expected outputs for the inputs currently driven; they appear after the next edge.
    task automatic tick(input logic er);
        exp_t e;
        e.pwm   = (en && run) ? ((cnt < act) ^ pol) : pol;
        e.pulse = en && run && (cnt == act) && (act != 16'd0);
        if (en && roll) exp_irq = 1'b1;
        else if (clr)   exp_irq = 1'b0;
        e.irq = exp_irq;
        e.rdy = er;
        e.tgt = 32'(cyc + 1);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic advance();
        if (run) begin
            if (cnt == 16'd9) begin
                cnt  = 16'd0;
                roll = 1'b1;
            end else begin
                cnt  = cnt + 16'd1;
                roll = 1'b0;
            end
        end else begin
            roll = 1'b0;
        end
    endtask

    task automatic run_to_roll(input logic er);
        while (!roll) begin
            tick(er);
            advance();
        end
    endtask

    task automatic period();
        repeat (10) begin
            tick(1'b1);
            advance();
        end
    endtask

    // Write while running: old duty holds until the next rollover, then the new one applies.
    task automatic write_running(input logic [15:0] v);
        dvalid = 1'b1;
        dval   = v;
        tick(1'b0);
        advance();
        dvalid = 1'b0;
        run_to_roll(1'b0);
        act = v;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].tgt <= 32'(cyc)) begin
                e = q.pop_front();
                check1("pwm", pwm, e.pwm);
                check1("pulse", pulse, e.pulse);
                check1("irq", irq, e.irq);
                check1("ready", dready, e.rdy);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int guard;
        rst = 1'b1; en = 1'b1; pol = 1'b0; run = 1'b0; cnt = 16'd0; roll = 1'b0;
        dvalid = 1'b0; dval = 16'd0; clr = 1'b0; act = 16'd0; exp_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_pwm", pwm, 1'b0);
        check1("reset_pulse", pulse, 1'b0);
        check1("reset_irq", irq, 1'b0);
        check1("reset_ready", dready, 1'b1);
        rst = 1'b0;

        // Counter stopped: write goes straight to active, ready never drops.
        dval = 16'd4; dvalid = 1'b1;
        tick(1'b1);
        dvalid = 1'b0; act = 16'd4;
        tick(1'b1);
        tick(1'b1);

        // Running, duty 4.
        run = 1'b1; cnt = 16'd0; roll = 1'b0;
        repeat (22) begin
            tick(1'b1);
            advance();
        end

        // Mid-period write of 7 at count 2; later held-valid value 9 must be ignored.
        dvalid = 1'b1; dval = 16'd7;
        tick(1'b0);
        advance();
        dval = 16'd9;
        repeat (3) begin
            tick(1'b0);
            advance();
        end
        dvalid = 1'b0;
        run_to_roll(1'b0);
        act = 16'd7;
        period();

        // Boundary duties and polarity; each write lands on a rollover cycle.
        write_running(16'd0);
        period();
        write_running(16'd10);
        period();
        write_running(16'hFFFF);
        period();
        pol = 1'b1;
        period();
        write_running(16'd0);
        period();
        pol = 1'b0;
        write_running(16'd4);
        period();

        // Clear on a rollover cycle: set wins; the following clear takes effect.
        clr = 1'b1;
        tick(1'b1);
        advance();
        tick(1'b1);
        advance();
        clr = 1'b0;

        // Enable low across a rollover.
        while (cnt != 16'd8) begin
            tick(1'b1);
            advance();
        end
        en = 1'b0;
        repeat (3) begin
            tick(1'b1);
            advance();
        end
        en = 1'b1;
        repeat (12) begin
            tick(1'b1);
            advance();
        end

        // Reset while a write is pending.
        dvalid = 1'b1; dval = 16'd2;
        tick(1'b0);
        advance();
        dvalid = 1'b0;
        tick(1'b0);
        advance();
        #2;
        rst = 1'b1;
        #1;
        check1("midreset_pwm", pwm, 1'b0);
        check1("midreset_pulse", pulse, 1'b0);
        check1("midreset_irq", irq, 1'b0);
        check1("midreset_ready", dready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0; exp_irq = 1'b0; act = 16'd0; cnt = 16'd0; roll = 1'b0;
        repeat (12) begin
            tick(1'b1);
            advance();
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #3;
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
